caregiver_monitor: RTL and testbench

CAREGIVER_MONITOR -- requirements
Module: caregiver_monitor

---
 rtl/caregiver_monitor_pkg.sv | 14 +
 rtl/miss_counter.sv | 47 ++++
 rtl/caregiver_monitor.sv | 93 +++++++++
 tb/tb_caregiver_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/caregiver_monitor_pkg.sv
// Shared types and constants for the caregiver monitor: FSM state encoding and
// the per-compartment miss counter width.
package caregiver_monitor_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAlert    = 2'd1,
    StEscalate = 2'd2,
    StCleared  = 2'd3
  } state_e;

endpackage

// File: rtl/miss_counter.sv
// One compartment: rising-edge detector on notify, falling-edge "dose taken"
// detector on should_eat, and a saturating count of consecutive misses.
module miss_counter
  import caregiver_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             notify,
  input  logic             should_eat,
  output logic             miss_edge,
  output logic [CNT_W-1:0] cnt
);

  logic             notify_q;
  logic             should_eat_q;
  logic             taken;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign miss_edge = notify & ~notify_q;
  // A taken event needs notify low, so it can never coincide with a miss edge.
  assign taken     = should_eat_q & ~should_eat & ~notify;

  always_comb begin
    cnt_d = cnt_q;
    if (taken) begin
      cnt_d = '0;
    end else if (miss_edge && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      notify_q     <= 1'b0;
      should_eat_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      notify_q     <= notify;
      should_eat_q <= should_eat;
      cnt_q        <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/caregiver_monitor.sv
// Medication-box caregiver monitor: latches missed doses, alerts the caregiver,
// escalates when the alert is not acknowledged in time, and tracks chronic misses.
module caregiver_monitor
  import caregiver_monitor_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT   = 8,
  parameter int unsigned CHRONIC_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       shouldEat,
  input  logic [3:0]       notify,
  input  logic             ack,
  input  logic [1:0]       sel,
  output logic [3:0]       alert,
  output logic             escalate,
  output logic             ack_done,
  output logic [3:0]       chronic,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned TimerW = 8;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        clr;
  logic [3:0]        miss_edges;
  logic [CNT_W-1:0]  miss_cnt [4];

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    miss_counter u_miss_counter (
      .clk        (clk),
      .rst        (rst),
      .notify     (notify[i]),
      .should_eat (shouldEat[i]),
      .miss_edge  (miss_edges[i]),
      .cnt        (miss_cnt[i])
    );
    assign chronic[i] = (miss_cnt[i] >= CNT_W'(CHRONIC_LIMIT));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) begin
          state_d = StAlert;
          timer_d = '0;
        end
      end
      StAlert: begin
        if (ack) begin
          state_d = StCleared;
        end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
          state_d = StEscalate;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StEscalate: begin
        if (ack) begin
          state_d = StCleared;
        end
      end
      StCleared: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Misses arriving on the clearing edge are kept so they re-alert.
    clr       = ((state_d == StCleared) && (state_q != StCleared)) ? 4'hf : 4'h0;
    pending_d = (pending_q & ~clr) | miss_edges;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign alert      = pending_q;
  assign escalate   = (state_q == StEscalate);
  assign ack_done   = (state_q == StCleared);
  assign miss_count = miss_cnt[sel];

endmodule

// File: tb/tb_caregiver_monitor.sv
// Scoreboard bench for caregiver_monitor: expected output snapshots are queued
// with each stimulus step and compared after the following clock edge.
module tb_caregiver_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] should_eat;
  logic [3:0] notify;
  logic       ack;
  logic [1:0] sel;
  logic [3:0] alert;
  logic       escalate;
  logic       ack_done;
  logic [3:0] chronic;
  logic [3:0] miss_count;

  int checks   = 0;
  int failures = 0;

  // Snapshot layout: {alert, escalate, ack_done, chronic, miss_count}.
  localparam logic [13:0] MAll = 14'h3fff;
  localparam logic [13:0] MEsc = 14'h0200;
  localparam logic [13:0] MChr = 14'h00f0;
  localparam logic [13:0] MMc  = 14'h000f;

  typedef struct {
    string       name;
    logic [13:0] exp;
    logic [13:0] mask;
  } exp_t;

  exp_t exp_q[$];

  caregiver_monitor #(
    .ACK_TIMEOUT   (8),
    .CHRONIC_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .shouldEat  (should_eat),
    .notify     (notify),
    .ack        (ack),
    .sel        (sel),
    .alert      (alert),
    .escalate   (escalate),
    .ack_done   (ack_done),
    .chronic    (chronic),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pk(input logic [3:0] a, input logic e, input logic d,
                                     input logic [3:0] c, input logic [3:0] m);
    return {a, e, d, c, m};
  endfunction

  function automatic logic [13:0] obs();
    return {alert, escalate, ack_done, chronic, miss_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t ent;
    rst = 1'b1; should_eat = '0; notify = '0; ack = 1'b0; sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      exp_q.push_back('{$sformatf("reset_%0d", i), 14'h0, MAll});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
  endtask

  // Single miss on bit1, second miss on bit0 mid-ALERT must not restart the timer.
  task automatic test_timeout();
    exp_t ent;
    sel = 2'd1;
    for (int k = 1; k <= 12; k++) begin
      notify = (k == 1) ? 4'b0010 : (k == 5) ? 4'b0001 : 4'b0000;
      exp_q.push_back('{$sformatf("timeout_k%0d", k),
                        pk((k >= 5) ? 4'b0011 : 4'b0010, (k >= 10), 1'b0, 4'h0, 4'd1), MAll});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
    notify = '0;
  endtask

  // From ESCALATE: ack with coincident miss on bit2, then ack at timer=3, then ack in IDLE.
  task automatic test_ack_clear();
    exp_t ent;
    sel = 2'd2;
    for (int s = 1; s <= 20; s++) begin
      ack    = (s == 1) || (s == 7) || (s >= 10 && s <= 12);
      notify = (s == 1) ? 4'b0100 : 4'b0000;
      exp_q.push_back('{$sformatf("ack_s%0d", s),
                        pk((s <= 6) ? 4'b0100 : 4'b0000, 1'b0, (s == 1) || (s == 7), 4'h0, 4'd1),
                        MAll});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_chronic();
    exp_t       ent;
    logic [3:0] seq [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] emc [6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    rst = 1'b1; notify = '0;
    tick();
    rst = 1'b0;
    sel = 2'd1;
    for (int h = 0; h < 6; h++) begin
      notify = seq[h];
      exp_q.push_back('{$sformatf("hold_%0d", h), pk(4'h0, 1'b0, 1'b0, 4'h0, emc[h]), MMc});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
    sel = 2'd0;
    for (int p = 1; p <= 16; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        notify = (ph == 0) ? 4'b0001 : 4'b0000;
        exp_q.push_back('{$sformatf("chronic_p%0d_%0d", p, ph),
                          pk(4'h0, 1'b0, 1'b0, {3'b000, (p >= 3)}, (p > 15) ? 4'd15 : 4'(p)),
                          MMc | MChr});
        tick();
        ent = exp_q.pop_front();
        checks++;
        if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
          failures++;
          $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
        end
      end
    end
  endtask

  // bit3: three misses, a taken dose clears it, a fall with notify high is a miss.
  task automatic test_taken();
    exp_t       ent;
    logic [3:0] se  [5] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] nt  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [3:0] emc [5] = '{4'd3, 4'd0, 4'd0, 4'd1, 4'd1};
    logic [3:0] ech [5] = '{4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    sel = 2'd3;
    for (int p = 1; p <= 3; p++) begin
      notify = 4'b1000;
      exp_q.push_back('{$sformatf("taken_miss%0d", p),
                        pk(4'h0, 1'b0, 1'b0, {(p >= 3), 3'b001}, 4'(p)), MMc | MChr});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
      notify = 4'b0000;
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      should_eat = se[s];
      notify     = nt[s];
      exp_q.push_back('{$sformatf("taken_s%0d", s), pk(4'h0, 1'b0, 1'b0, ech[s], emc[s]),
                        MMc | MChr});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
  endtask

  task automatic test_reset_abort();
    exp_t ent;
    rst = 1'b1; notify = '0; should_eat = '0; ack = 1'b0;
    tick();
    rst = 1'b0;
    sel = 2'd2;
    for (int p = 0; p < 5; p++) begin
      notify = 4'b0100;
      tick();
      notify = 4'b0000;
      tick();
    end
    for (int i = 0; i < 20 && !escalate; i++) tick();
    exp_q.push_back('{"abort_in_escalate", pk(4'h0, 1'b1, 1'b0, 4'h0, 4'd5), MEsc | MMc});
    ent = exp_q.pop_front();
    checks++;
    if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
      failures++;
      $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
    end
    for (int s = 0; s < 4; s++) begin
      rst = (s == 0);
      exp_q.push_back('{$sformatf("abort_s%0d", s), 14'h0, MAll});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
    // notify already high across reset release counts as a miss.
    sel = 2'd0;
    for (int s = 0; s < 2; s++) begin
      rst    = (s == 0);
      notify = 4'b0001;
      exp_q.push_back('{$sformatf("rst_release_s%0d", s),
                        (s == 0) ? 14'h0 : pk(4'b0001, 1'b0, 1'b0, 4'h0, 4'd1), MAll});
      tick();
      ent = exp_q.pop_front();
      checks++;
      if ((obs() & ent.mask) !== (ent.exp & ent.mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h", ent.name, obs() & ent.mask, ent.exp & ent.mask);
      end
    end
    notify = '0;
  endtask

  initial begin
    rst = 1'b1; should_eat = '0; notify = '0; ack = 1'b0; sel = 2'd0;
    test_reset();
    test_timeout();
    test_ack_clear();
    test_chronic();
    test_taken();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
